decimal_entry_encoder: RTL and testbench

Operand-entry block for the GCD datapath. It converts a decimal number keyed in one digit at a time (switch digit plus a strobe button) into a WIDTH-bit binary value, which is the inverse of the binary-to-two-digit-decimal display decoder. The block sits between the board's switches/buttons and the GCD core's operand inputs. It presents each completed operand on a valid/ready handshake and flags out-of-range or malformed entries.

---
 rtl/gcd_pkg.sv | 30 +++
 rtl/edge_pulse_sync.sv | 36 +++
 rtl/decimal_entry_encoder.sv | 122 ++++++++++++
 tb/tb_decimal_entry_encoder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types and width helpers for the GCD operand-entry path
// Contents: entry_state_t (entry FSM states), BCD_MAX (largest legal BCD digit),
//           DIGIT_W(digits) digit-counter width, ACC_W(digits) accumulator width.
package gcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2,
      ERROR = 2'd3
   } entry_state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   // Width needed to count 0..digits accepted digits.
   function automatic int DIGIT_W(input int digits);
      return $clog2(digits + 1);
   endfunction

   // Width needed to hold any value of up to 'digits' decimal digits.
   function automatic int ACC_W(input int digits);
      int p;
      p = 1;
      for (int i = 0; i < digits; i++) begin
         p = p * 10;
      end
      return $clog2(p);
   endfunction

endpackage

// File: rtl/edge_pulse_sync.sv
// rtl/edge_pulse_sync.sv - button synchronizer with rising-edge one-cycle pulse
// Ports: clk, rst (sync, active-high), btn_in (raw async button),
//        pulse (one-cycle high on each synchronized rising edge of btn_in).
module edge_pulse_sync (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic pulse
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;

   always_comb begin
      sync1_d = btn_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   // Reset to 1 so a button already held down at reset release is not seen as a press.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

   assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/decimal_entry_encoder.sv
// rtl/decimal_entry_encoder.sv - keyed decimal digits to binary operand with valid/ready
// Ports: clk, rst (sync, active-high); digit_in (BCD digit), digit_btn/enter_btn/clear_btn
//        (raw async buttons); value_out (operand), value_valid/value_ready (handshake),
//        error (entry rejected, held until clear), digits_entered (accepted digits),
//        busy (not idle). All outputs are registered.
module decimal_entry_encoder
   import gcd_pkg::*;
#(
   parameter int WIDTH     = 5,
   parameter int DIGITS    = 2,
   parameter int MAX_VALUE = 31
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [3:0]                   digit_in,
   input  logic                         digit_btn,
   input  logic                         enter_btn,
   input  logic                         clear_btn,
   output logic [WIDTH-1:0]             value_out,
   output logic                         value_valid,
   input  logic                         value_ready,
   output logic                         error,
   output logic [DIGIT_W(DIGITS)-1:0]   digits_entered,
   output logic                         busy
);

   localparam int AW = ACC_W(DIGITS);
   localparam int CW = DIGIT_W(DIGITS);
   // Headroom so acc*10+9 never wraps before the range compare.
   localparam int XW = AW + 4;

   logic dig_ev, ent_ev, clr_ev;

   edge_pulse_sync u_dig_sync (.clk(clk), .rst(rst), .btn_in(digit_btn), .pulse(dig_ev));
   edge_pulse_sync u_ent_sync (.clk(clk), .rst(rst), .btn_in(enter_btn), .pulse(ent_ev));
   edge_pulse_sync u_clr_sync (.clk(clk), .rst(rst), .btn_in(clear_btn), .pulse(clr_ev));

   entry_state_t      state_q, state_d;
   logic [AW-1:0]     acc_q, acc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              valid_q, valid_d;
   logic              error_q, error_d;
   logic              busy_q, busy_d;

   logic [XW-1:0]     acc_ext;
   logic [XW-1:0]     acc_next;
   logic              dig_bad;
   logic              dig_take;

   always_comb begin
      acc_ext  = {4'b0000, acc_q};
      acc_next = (acc_ext << 3) + (acc_ext << 1) + {{AW{1'b0}}, digit_in};
      dig_bad  = (digit_in > BCD_MAX) || (cnt_q == CW'(DIGITS)) || (acc_next > XW'(MAX_VALUE));
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state; clear beats enter beats digit
   always_comb begin
      state_d = state_q;
      if (clr_ev) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (dig_ev) state_d = dig_bad ? ERROR : ACCUM;
            ACCUM:   if (ent_ev) state_d = HOLD;
                     else if (dig_ev && dig_bad) state_d = ERROR;
            HOLD:    if (valid_q && value_ready) state_d = IDLE;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
         endcase
      end
   end

   // Output and datapath next values
   always_comb begin
      dig_take = !clr_ev && dig_ev && !dig_bad &&
                 ((state_q == IDLE) || ((state_q == ACCUM) && !ent_ev));
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      if (state_d == IDLE) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (dig_take) begin
         acc_d = acc_next[AW-1:0];
         cnt_d = cnt_q + 1'b1;
      end
      valid_d = (state_d == HOLD);
      error_d = (state_d == ERROR);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         error_q <= error_d;
         busy_q  <= busy_d;
      end
   end

   assign value_out      = acc_q[WIDTH-1:0];
   assign value_valid    = valid_q;
   assign error          = error_q;
   assign digits_entered = cnt_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_decimal_entry_encoder.sv
// tb/tb_decimal_entry_encoder.sv - self-checking bench for decimal_entry_encoder
module tb_decimal_entry_encoder;

   localparam int W  = 5;
   localparam int D  = 2;
   localparam int MX = 31;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] digit_in = 4'd0;
   logic       digit_btn = 1'b0;
   logic       enter_btn = 1'b0;
   logic       clear_btn = 1'b0;
   logic       value_ready = 1'b0;
   logic [W-1:0] value_out;
   logic       value_valid;
   logic       error;
   logic [1:0] digits_entered;
   logic       busy;

   decimal_entry_encoder #(.WIDTH(W), .DIGITS(D), .MAX_VALUE(MX)) dut (
      .clk(clk), .rst(rst), .digit_in(digit_in), .digit_btn(digit_btn),
      .enter_btn(enter_btn), .clear_btn(clear_btn), .value_out(value_out),
      .value_valid(value_valid), .value_ready(value_ready), .error(error),
      .digits_entered(digits_entered), .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural model: operand value, digit count, offered flag, error flag.
   typedef struct {
      int val;
      int nd;
      bit off;
      bit err;
   } mdl_t;

   mdl_t m = '{0, 0, 1'b0, 1'b0};

   // Raw button samples at the last three edges; a press becomes an event
   // two edges after it is first sampled.
   bit [2:0] hd = 3'b111;
   bit [2:0] he = 3'b111;
   bit [2:0] hc = 3'b111;

   function automatic mdl_t mnext(mdl_t c, bit r, bit de, bit ee, bit ce, int d, bit rdy);
      mdl_t n;
      int nv;
      n = c;
      if (r || ce) return '{0, 0, 1'b0, 1'b0};
      if (c.err) return n;
      if (c.off) begin
         if (rdy) n = '{0, 0, 1'b0, 1'b0};
         return n;
      end
      if (ee && c.nd > 0) begin
         n.off = 1'b1;
         return n;
      end
      if (de) begin
         nv = c.val * 10 + d;
         if (d > 9 || c.nd == D || nv > MX) n.err = 1'b1;
         else begin
            n.val = nv;
            n.nd  = c.nd + 1;
         end
      end
      return n;
   endfunction

   always @(posedge clk) begin
      m  <= mnext(m, rst, hd[1] & ~hd[2], he[1] & ~he[2], hc[1] & ~hc[2],
                  int'(digit_in), value_ready);
      hd <= rst ? 3'b111 : {hd[1:0], digit_btn};
      he <= rst ? 3'b111 : {he[1:0], enter_btn};
      hc <= rst ? 3'b111 : {hc[1:0], clear_btn};
   end

   int    n_pass = 0;
   int    n_tot  = 0;
   bit    chk_en = 1'b0;
   bit    lit_req = 1'b0;
   int    lit_sel = 0;
   int    lit_exp = 0;
   string lit_name = "";
   int    aux = 0;

   task automatic cmp(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   function automatic int lit_val(input int sel);
      case (sel)
         0:       return int'(value_out);
         1:       return int'(value_valid);
         2:       return int'(error);
         3:       return int'(digits_entered);
         4:       return int'(busy);
         5:       return aux;
         6:       return m.val;
         default: return m.nd;
      endcase
   endfunction

   // Single compare process: model vs DUT every cycle, plus literal expectations.
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("value_out", int'(value_out), m.val % 32);
         cmp("value_valid", int'(value_valid), int'(m.off));
         cmp("error", int'(error), int'(m.err));
         cmp("digits_entered", int'(digits_entered), m.nd);
         cmp("busy", int'(busy), int'(m.nd > 0 || m.off || m.err));
         if (lit_req) cmp(lit_name, lit_val(lit_sel), lit_exp);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   // Checks the selected value after the next rising edge.
   task automatic expect_v(input string nm, input int sel, input int e);
      lit_name = nm;
      lit_sel  = sel;
      lit_exp  = e;
      lit_req  = 1'b1;
      @(negedge clk);
      #1;
      lit_req = 1'b0;
   endtask

   task automatic press_dig(input logic [3:0] d);
      digit_in  = d;
      digit_btn = 1'b1;
      tick(4);
      digit_btn = 1'b0;
      tick(4);
   endtask

   task automatic press_ent();
      enter_btn = 1'b1;
      tick(4);
      enter_btn = 1'b0;
      tick(4);
   endtask

   task automatic press_clr();
      clear_btn = 1'b1;
      tick(4);
      clear_btn = 1'b0;
      tick(4);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      tick(1);
      chk_en = 1'b1;
      expect_v("reset value_out", 0, 0);
      expect_v("reset value_valid", 1, 0);
      expect_v("reset busy", 4, 0);
      rst = 1'b0;
      tick(2);

      // 2, 7, enter with consumer stalled
      press_dig(4'd2);
      press_dig(4'd7);
      press_ent();
      aux = 0;
      repeat (20) begin
         if (value_valid) aux++;
         tick(1);
      end
      expect_v("valid held 20 cycles", 5, 20);
      expect_v("hold value_out 27", 0, 27);
      expect_v("hold digits 2", 3, 2);
      expect_v("model value 27", 6, 27);
      value_ready = 1'b1;
      expect_v("ack drops valid", 1, 0);
      value_ready = 1'b0;
      expect_v("ack busy low", 4, 0);
      tick(2);

      // 3, 2 overflows 31
      press_dig(4'd3);
      press_dig(4'd2);
      expect_v("overflow error", 2, 1);
      expect_v("overflow keeps 3", 0, 3);
      press_clr();
      expect_v("clear error low", 2, 0);
      expect_v("clear busy low", 4, 0);

      // non-BCD digit, error exactly two edges after first sample
      digit_in  = 4'hA;
      digit_btn = 1'b1;
      expect_v("bad digit edge k", 2, 0);
      expect_v("bad digit edge k+1", 2, 0);
      expect_v("bad digit edge k+2", 2, 1);
      tick(1);
      digit_btn = 1'b0;
      tick(3);
      press_ent();
      press_dig(4'd1);
      expect_v("error sticky", 2, 1);
      expect_v("error value 0", 0, 0);
      press_clr();

      // 0, 5, 1 exceeds digit count
      press_dig(4'd0);
      press_dig(4'd5);
      expect_v("value 5 before third", 0, 5);
      expect_v("model digits 2", 7, 2);
      press_dig(4'd1);
      expect_v("too many digits error", 2, 1);
      expect_v("too many digits keeps 5", 0, 5);
      press_clr();

      // enter and clear together while accumulating 9
      press_dig(4'd9);
      expect_v("acc 9", 0, 9);
      enter_btn = 1'b1;
      clear_btn = 1'b1;
      aux = 0;
      repeat (4) begin
         if (value_valid) aux = 1;
         tick(1);
      end
      enter_btn = 1'b0;
      clear_btn = 1'b0;
      repeat (6) begin
         if (value_valid) aux = 1;
         tick(1);
      end
      expect_v("enter+clear value 0", 0, 0);
      expect_v("enter+clear never valid", 5, 0);
      expect_v("enter+clear idle", 4, 0);

      // button held through reset release
      digit_in  = 4'd6;
      digit_btn = 1'b1;
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(50);
      expect_v("held button no digit", 3, 0);
      expect_v("held button idle", 4, 0);
      digit_btn = 1'b0;
      tick(3);
      press_dig(4'd6);
      expect_v("re-press value 6", 0, 6);
      expect_v("re-press digits 1", 3, 1);
      press_clr();

      // ready held high: exactly one valid cycle
      value_ready = 1'b1;
      press_dig(4'd1);
      press_dig(4'd4);
      enter_btn = 1'b1;
      aux = 0;
      repeat (4) begin
         if (value_valid) aux++;
         tick(1);
      end
      enter_btn = 1'b0;
      repeat (6) begin
         if (value_valid) aux++;
         tick(1);
      end
      expect_v("one valid cycle", 5, 1);
      expect_v("after handshake value 0", 0, 0);
      expect_v("after handshake digits 0", 3, 0);
      value_ready = 1'b0;
      tick(2);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
